multicycle_ctrl: RTL and testbench

Parametrised multicycle control unit for the 16BitNotRISC CPU family. It fetches each instruction, decodes it, and sequences the datapath through the instruction's states. It drives the program counter, instruction register, data memory, register file and ALU. It extends the first-generation controller with four additions:
- configurable field widths;
- logic ops, absolute jumps and conditional relative branches;
- a resumable halt and a single-step debug mode;
- sticky illegal-opcode reporting.

---
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the 16BitNotRISC family: fetch/decode/execute
// sequencing with logic ops, jumps, relative branches, halt/step and illegal-op flag.
module multicycle_ctrl #(
  parameter int RA_W = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [4+3*RA_W-1:0]   IR,
  input  logic [2*RA_W-1:0]     PC,
  input  logic                  ALU_Z,
  input  logic                  Resume,
  input  logic                  Step,
  output logic                  PC_CLR,
  output logic                  PC_IC,
  output logic                  PC_LD,
  output logic [2*RA_W-1:0]     PC_NEXT,
  output logic                  IR_LD,
  output logic [2*RA_W-1:0]     D_ADDR,
  output logic                  D_WR,
  output logic                  RF_S,
  output logic                  RF_W_EN,
  output logic [RA_W-1:0]       RF_A_ADDR,
  output logic [RA_W-1:0]       RF_B_ADDR,
  output logic [RA_W-1:0]       RF_W_ADDR,
  output logic [3:0]            ALU_S,
  output logic                  InstrDone,
  output logic                  Halted,
  output logic                  Illegal,
  output logic [3:0]            State_Out,
  output logic [3:0]            NextState_Out
);

  localparam int IW   = 4 + 3*RA_W;
  localparam int PC_W = 2*RA_W;
  localparam int DA_W = 2*RA_W;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_BEQ   = 4'h9;
  localparam logic [3:0] OP_BNE   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    S_INIT   = 4'h0,
    S_FETCH  = 4'h1,
    S_DECODE = 4'h2,
    S_LOAD_A = 4'h3,
    S_LOAD_B = 4'h4,
    S_STORE  = 4'h5,
    S_ALU    = 4'h6,
    S_BRANCH = 4'h7,
    S_JUMP   = 4'h8,
    S_HALT   = 4'h9,
    S_NOOP   = 4'hA,
    S_PAUSE  = 4'hB
  } state_t;

  state_t            state_q, state_d;
  logic [DA_W-1:0]   d_addr_q, d_addr_d;
  logic              illegal_q, illegal_d;

  logic [3:0]        op;
  logic [RA_W-1:0]   f2, f1, f0;
  logic              op_alu, op_bad, br_taken;
  logic [PC_W-1:0]   br_target;
  state_t            done_next, exit_next;

  assign op = IR[IW-1 -: 4];
  assign f2 = IR[3*RA_W-1 -: RA_W];
  assign f1 = IR[2*RA_W-1 -: RA_W];
  assign f0 = IR[RA_W-1:0];

  assign op_alu = (op >= OP_ADD) && (op <= OP_XOR);
  assign op_bad = (op > OP_BNE) && (op < OP_HALT);

  // f0 is a signed word offset relative to the already-incremented PC.
  assign br_target = PC + {{RA_W{f0[RA_W-1]}}, f0};
  assign br_taken  = ((op == OP_BEQ) && ALU_Z) || ((op == OP_BNE) && !ALU_Z);

  assign done_next = Step ? S_PAUSE : S_FETCH;
  assign exit_next = Resume ? S_FETCH : state_q;

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (op_alu)                              state_d = S_ALU;
        else if (op == OP_STORE)                 state_d = S_STORE;
        else if (op == OP_LOAD)                  state_d = S_LOAD_A;
        else if (op == OP_JMP)                   state_d = S_JUMP;
        else if (op == OP_BEQ || op == OP_BNE)   state_d = S_BRANCH;
        else if (op == OP_HALT)                  state_d = S_HALT;
        else                                     state_d = S_NOOP;
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B, S_STORE, S_ALU, S_BRANCH, S_JUMP, S_NOOP:
                state_d = done_next;
      S_HALT, S_PAUSE:
                state_d = exit_next;
      default:  state_d = S_INIT;
    endcase
  end

  // Data address is latched once per LOAD/STORE so it stays valid through the access.
  always_comb begin
    d_addr_d  = d_addr_q;
    illegal_d = illegal_q;
    if (state_q == S_DECODE) begin
      if (op == OP_LOAD)  d_addr_d = {f2, f1};
      if (op == OP_STORE) d_addr_d = {f1, f0};
      if (op_bad)         illegal_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_INIT;
      d_addr_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_addr_q  <= d_addr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    PC_CLR    = 1'b0;
    PC_IC     = 1'b0;
    PC_LD     = 1'b0;
    PC_NEXT   = '0;
    IR_LD     = 1'b0;
    D_WR      = 1'b0;
    RF_S      = 1'b0;
    RF_W_EN   = 1'b0;
    RF_A_ADDR = '0;
    RF_B_ADDR = '0;
    RF_W_ADDR = '0;
    ALU_S     = 4'h0;
    InstrDone = 1'b0;
    Halted    = 1'b0;
    case (state_q)
      S_INIT:   PC_CLR = 1'b1;
      S_FETCH:  IR_LD  = 1'b1;
      S_DECODE: PC_IC  = 1'b1;
      S_LOAD_A: ;
      S_LOAD_B: begin
        RF_S      = 1'b1;
        RF_W_EN   = 1'b1;
        RF_W_ADDR = f0;
        InstrDone = 1'b1;
      end
      S_STORE: begin
        RF_A_ADDR = f2;
        D_WR      = 1'b1;
        InstrDone = 1'b1;
      end
      S_ALU: begin
        RF_A_ADDR = f2;
        RF_B_ADDR = f1;
        RF_W_ADDR = f0;
        RF_W_EN   = 1'b1;
        ALU_S     = op;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        RF_A_ADDR = f2;
        RF_B_ADDR = f1;
        ALU_S     = OP_SUB;
        InstrDone = 1'b1;
        if (br_taken) begin
          PC_LD   = 1'b1;
          PC_NEXT = br_target;
        end
      end
      S_JUMP: begin
        PC_LD     = 1'b1;
        PC_NEXT   = {f1, f0};
        InstrDone = 1'b1;
      end
      S_NOOP:   InstrDone = 1'b1;
      S_HALT, S_PAUSE:
                Halted = 1'b1;
      default: ;
    endcase
  end

  assign D_ADDR        = d_addr_q;
  assign Illegal       = illegal_q;
  assign State_Out     = state_q;
  assign NextState_Out = state_d;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle stimulus/expectation records queued,
// then replayed and compared one clock at a time.
module tb_multicycle_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] IR = '0;
  logic [7:0]  PC = '0;
  logic        ALU_Z = 1'b0, Resume = 1'b0, Step = 1'b0;
  logic        PC_CLR, PC_IC, PC_LD, IR_LD, D_WR, RF_S, RF_W_EN;
  logic        InstrDone, Halted, Illegal;
  logic [7:0]  PC_NEXT, D_ADDR;
  logic [3:0]  RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S, State_Out, NextState_Out;

  always #5 Clock = ~Clock;

  multicycle_ctrl #(.RA_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .PC(PC), .ALU_Z(ALU_Z),
    .Resume(Resume), .Step(Step),
    .PC_CLR(PC_CLR), .PC_IC(PC_IC), .PC_LD(PC_LD), .PC_NEXT(PC_NEXT),
    .IR_LD(IR_LD), .D_ADDR(D_ADDR), .D_WR(D_WR), .RF_S(RF_S), .RF_W_EN(RF_W_EN),
    .RF_A_ADDR(RF_A_ADDR), .RF_B_ADDR(RF_B_ADDR), .RF_W_ADDR(RF_W_ADDR),
    .ALU_S(ALU_S), .InstrDone(InstrDone), .Halted(Halted), .Illegal(Illegal),
    .State_Out(State_Out), .NextState_Out(NextState_Out)
  );

  localparam logic [3:0] INIT = 4'h0, FETCH = 4'h1, DECODE = 4'h2, LOAD_A = 4'h3,
                         LOAD_B = 4'h4, STORE = 4'h5, ALU = 4'h6, BRANCH = 4'h7,
                         JUMP = 4'h8, HALT = 4'h9, NOOP = 4'hA, PAUSE = 4'hB;

  typedef struct packed {
    logic [3:0] st, nst;
    logic       pc_clr, pc_ic, pc_ld;
    logic [7:0] pc_next;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr, rf_s, rf_wen;
    logic [3:0] ra, rb, rw, alus;
    logic       done, halted, illegal;
  } obs_t;

  typedef struct packed {
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        z, step, res, rst;
  } stim_t;

  typedef struct {
    string nm;
    stim_t s;
    obs_t  e;
  } cyc_t;

  typedef struct {
    string       nm;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        z;
    logic [3:0]  ex;
    logic        upd;
    logic [7:0]  da;
    logic        ill;
    obs_t        x;
  } vec_t;

  cyc_t       q[$];
  vec_t       vt[$];
  int         errors = 0, checks = 0;
  logic [7:0] exp_da = '0;
  logic       exp_ill = 1'b0;
  obs_t       act;

  assign act = {State_Out, NextState_Out, PC_CLR, PC_IC, PC_LD, PC_NEXT, IR_LD,
                D_ADDR, D_WR, RF_S, RF_W_EN, RF_A_ADDR, RF_B_ADDR, RF_W_ADDR,
                ALU_S, InstrDone, Halted, Illegal};

  function automatic obs_t mk(logic [3:0] st, logic [3:0] nst);
    obs_t o = '0;
    o.st = st; o.nst = nst; o.d_addr = exp_da; o.illegal = exp_ill;
    return o;
  endfunction

  function automatic obs_t fx(logic [3:0] ra, logic [3:0] rb, logic [3:0] rw, logic [3:0] alus,
                              logic wen, logic rfs, logic dwr, logic pcld, logic [7:0] pcn);
    obs_t o = '0;
    o.ra = ra; o.rb = rb; o.rw = rw; o.alus = alus; o.rf_wen = wen;
    o.rf_s = rfs; o.d_wr = dwr; o.pc_ld = pcld; o.pc_next = pcn;
    return o;
  endfunction

  function automatic stim_t sx(logic [15:0] ir, logic [7:0] pc, logic z,
                               logic step, logic res, logic rst);
    stim_t s;
    s.ir = ir; s.pc = pc; s.z = z; s.step = step; s.res = res; s.rst = rst;
    return s;
  endfunction

  function automatic vec_t mkv(string nm, logic [15:0] ir, logic [7:0] pc, logic z,
                               logic [3:0] ex, logic upd, logic [7:0] da, logic ill, obs_t x);
    vec_t v;
    v.nm = nm; v.ir = ir; v.pc = pc; v.z = z; v.ex = ex;
    v.upd = upd; v.da = da; v.ill = ill; v.x = x;
    return v;
  endfunction

  task automatic push(string nm, stim_t s, obs_t e);
    cyc_t c;
    c.nm = nm; c.s = s; c.e = e;
    q.push_back(c);
  endtask

  task automatic push_init(string nm, logic rst);
    obs_t e;
    e = mk(INIT, FETCH);
    e.pc_clr = 1'b1;
    push(nm, sx(16'h0, 8'h0, 1'b0, 1'b0, 1'b0, rst), e);
  endtask

  task automatic push_fd(string nm, stim_t s, logic [3:0] nst);
    obs_t e;
    e = mk(FETCH, DECODE); e.ir_ld = 1'b1;
    push({nm, ".fetch"}, s, e);
    e = mk(DECODE, nst); e.pc_ic = 1'b1;
    push({nm, ".decode"}, s, e);
  endtask

  task automatic add_instr(vec_t v);
    stim_t s;
    obs_t  e;
    s = sx(v.ir, v.pc, v.z, 1'b0, 1'b0, 1'b0);
    push_fd(v.nm, s, (v.ex == LOAD_B) ? LOAD_A : v.ex);
    if (v.upd) exp_da = v.da;
    if (v.ill) exp_ill = 1'b1;
    if (v.ex == LOAD_B) push({v.nm, ".load_a"}, s, mk(LOAD_A, LOAD_B));
    e = v.x;
    e.st = v.ex; e.nst = FETCH; e.done = 1'b1;
    e.d_addr = exp_da; e.illegal = exp_ill;
    push({v.nm, ".exec"}, s, e);
  endtask

  task automatic drain();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge Clock);
      IR = c.s.ir; PC = c.s.pc; ALU_Z = c.s.z;
      Step = c.s.step; Resume = c.s.res; Reset = c.s.rst;
      #1;
      checks++;
      if (act !== c.e) begin
        errors++;
        $display("FAIL %s: got st=%h nst=%h obs=%h, expected st=%h nst=%h obs=%h",
                 c.nm, act.st, act.nst, act, c.e.st, c.e.nst, c.e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    obs_t  e;
    stim_t s;

    vt.push_back(mkv("noop",    16'h0000, 8'h00, 0, NOOP,   0, 8'h00, 0, fx(0,0,0,0,0,0,0,0,8'h00)));
    vt.push_back(mkv("noop2",   16'h0000, 8'h01, 0, NOOP,   0, 8'h00, 0, fx(0,0,0,0,0,0,0,0,8'h00)));
    vt.push_back(mkv("load",    16'h2A53, 8'h02, 0, LOAD_B, 1, 8'hA5, 0, fx(0,0,3,0,1,1,0,0,8'h00)));
    vt.push_back(mkv("store",   16'h17C4, 8'h03, 0, STORE,  1, 8'hC4, 0, fx(7,0,0,0,0,0,1,0,8'h00)));
    vt.push_back(mkv("add",     16'h3123, 8'h04, 0, ALU,    0, 8'h00, 0, fx(1,2,3,3,1,0,0,0,8'h00)));
    vt.push_back(mkv("sub",     16'h4567, 8'h05, 1, ALU,    0, 8'h00, 0, fx(5,6,7,4,1,0,0,0,8'h00)));
    vt.push_back(mkv("and",     16'h5ABC, 8'h06, 0, ALU,    0, 8'h00, 0, fx(4'hA,4'hB,4'hC,5,1,0,0,0,8'h00)));
    vt.push_back(mkv("or",      16'h6DEF, 8'h07, 0, ALU,    0, 8'h00, 0, fx(4'hD,4'hE,4'hF,6,1,0,0,0,8'h00)));
    vt.push_back(mkv("xor",     16'h7010, 8'h08, 0, ALU,    0, 8'h00, 0, fx(0,1,0,7,1,0,0,0,8'h00)));
    vt.push_back(mkv("beq_tk",  16'h912E, 8'h10, 1, BRANCH, 0, 8'h00, 0, fx(1,2,0,4,0,0,0,1,8'h0E)));
    vt.push_back(mkv("beq_nt",  16'h912E, 8'h10, 0, BRANCH, 0, 8'h00, 0, fx(1,2,0,4,0,0,0,0,8'h00)));
    vt.push_back(mkv("beq_wrap",16'h9127, 8'hFE, 1, BRANCH, 0, 8'h00, 0, fx(1,2,0,4,0,0,0,1,8'h05)));
    vt.push_back(mkv("bne_tk",  16'hA345, 8'h20, 0, BRANCH, 0, 8'h00, 0, fx(3,4,0,4,0,0,0,1,8'h25)));
    vt.push_back(mkv("bne_nt",  16'hA345, 8'h20, 1, BRANCH, 0, 8'h00, 0, fx(3,4,0,4,0,0,0,0,8'h00)));
    vt.push_back(mkv("bne_neg", 16'hA3F8, 8'h05, 0, BRANCH, 0, 8'h00, 0, fx(3,4'hF,0,4,0,0,0,1,8'hFD)));
    vt.push_back(mkv("jmp",     16'h80F0, 8'h30, 0, JUMP,   0, 8'h00, 0, fx(0,0,0,0,0,0,0,1,8'hF0)));
    vt.push_back(mkv("illegal", 16'hC000, 8'h31, 0, NOOP,   0, 8'h00, 1, fx(0,0,0,0,0,0,0,0,8'h00)));
    vt.push_back(mkv("ill_E",   16'hE123, 8'h32, 0, NOOP,   0, 8'h00, 1, fx(0,0,0,0,0,0,0,0,8'h00)));
    vt.push_back(mkv("noop3",   16'h0000, 8'h33, 0, NOOP,   0, 8'h00, 0, fx(0,0,0,0,0,0,0,0,8'h00)));
    vt.push_back(mkv("load2",   16'h2F0E, 8'h34, 0, LOAD_B, 1, 8'hF0, 0, fx(0,0,4'hE,0,1,1,0,0,8'h00)));
    vt.push_back(mkv("store2",  16'h1A9B, 8'h35, 0, STORE,  1, 8'h9B, 0, fx(4'hA,0,0,0,0,0,1,0,8'h00)));

    // reset held two edges, then the INIT cycle after release
    push_init("rst0", 1'b1);
    push_init("rst1", 1'b1);
    push_init("init", 1'b0);
    for (int i = 0; i < vt.size(); i++) add_instr(vt[i]);

    // HALT held with Resume low, then released
    s = sx(16'hF000, 8'h40, 0, 0, 0, 0);
    push_fd("halt", s, HALT);
    e = mk(HALT, HALT); e.halted = 1'b1;
    for (int i = 0; i < 5; i++) push("halt.hold", s, e);
    s.res = 1'b1;
    e.nst = FETCH;
    push("halt.resume", s, e);
    add_instr(vt[0]);

    // Resume already high on entry: still one cycle in HALT
    s = sx(16'hF000, 8'h41, 0, 0, 1, 0);
    push_fd("halt_r", s, HALT);
    e = mk(HALT, FETCH); e.halted = 1'b1;
    push("halt_r.min", s, e);
    add_instr(vt[4]);

    // Step raised during the ALU cycle: pause after completion
    s = sx(16'h3123, 8'h50, 0, 0, 0, 0);
    push_fd("step", s, ALU);
    s.step = 1'b1;
    e = vt[4].x; e.st = ALU; e.nst = PAUSE; e.done = 1'b1;
    e.d_addr = exp_da; e.illegal = exp_ill;
    push("step.alu", s, e);
    e = mk(PAUSE, PAUSE); e.halted = 1'b1;
    push("pause.hold0", s, e);
    push("pause.hold1", s, e);
    s.res = 1'b1;
    e.nst = FETCH;
    push("pause.resume", s, e);
    add_instr(vt[0]);

    // Reset asserted during LOAD_A
    s = sx(16'h2123, 8'h60, 0, 0, 0, 0);
    push_fd("rstmid", s, LOAD_A);
    exp_da = 8'h12;
    s.rst = 1'b1; s.res = 1'b1; s.step = 1'b1;
    push("rstmid.load_a", s, mk(LOAD_A, LOAD_B));
    exp_da = 8'h00;
    exp_ill = 1'b0;
    push_init("rstmid.init", 1'b0);
    add_instr(vt[0]);

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
